// File: rtl/kernel_pkg.sv
// Shared definitions for the window-kernel stages: border width, FSM encodings, pad default.
package kernel_pkg;

    localparam int unsigned PAD_DEFAULT = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Pixels lost on each side by a k x k window.
    function automatic int unsigned border_w(input int unsigned k);
        return (k - 1) / 2;
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster (row, col) position counter with start/end-of-line and last-pixel flags.
module raster_pos_counter #(
    parameter  int unsigned WIDTH = 640,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          is_sol,
    output logic          is_eol,
    output logic          is_last
);

    logic [RW-1:0] row_d;
    logic [CW-1:0] col_d;

    // Next position: column wraps into the next row, last row wraps to the top.
    always_comb begin
        row_d = row;
        col_d = col;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (enable) begin
            if (col == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row == RW'(DEPTH - 1)) ? '0 : row + RW'(1);
            end else begin
                col_d = col + CW'(1);
            end
        end
    end

    // Flags are registered alongside the position so they always describe it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            is_sol  <= 1'b1;
            is_eol  <= (WIDTH == 1);
            is_last <= (WIDTH == 1) && (DEPTH == 1);
        end else begin
            row     <= row_d;
            col     <= col_d;
            is_sol  <= (col_d == '0);
            is_eol  <= (col_d == CW'(WIDTH - 1));
            is_last <= (col_d == CW'(WIDTH - 1)) && (row_d == RW'(DEPTH - 1));
        end
    end

endmodule

// File: rtl/kernel_border_pad.sv
// Re-inserts the border stripped by a KxK window stage, rebuilding a full raster
// with sof/eol/eof markers from the cropped interior stream.
module kernel_border_pad
    import kernel_pkg::*;
#(
    parameter int unsigned           WIDTH       = 640,
    parameter int unsigned           DEPTH       = 512,
    parameter int unsigned           KERNEL_SIZE = 3,
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = DATA_WIDTH'(PAD_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overlap
);

    localparam int unsigned B  = border_w(KERNEL_SIZE);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          is_sol, is_eol, is_last;
    logic          border_c, load_ok_c, load_c, start_c, drain_hs_c;

    assign border_c   = (row < RW'(B)) || (row >= RW'(DEPTH - B)) ||
                        (col < CW'(B)) || (col >= CW'(WIDTH - B));
    assign load_ok_c  = !out_valid || out_ready;
    assign start_c    = (state_q == ST_IDLE) && frame_start;
    assign drain_hs_c = (state_q == ST_DRAIN) && out_valid && out_ready;
    // Border beats need no input; interior beats wait for a pixel.
    assign load_c     = (state_q == ST_RUN) && load_ok_c && (border_c || in_valid);
    assign in_ready   = (state_q == ST_RUN) && !border_c && load_ok_c;

    raster_pos_counter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_c),
        .enable  (load_c),
        .row     (row),
        .col     (col),
        .is_sol  (is_sol),
        .is_eol  (is_eol),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start)         state_d = ST_RUN;
            ST_RUN:   if (load_c && is_last)   state_d = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Output register: holds the beat until accepted, reloads on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            busy        <= (state_d != ST_IDLE);
            frame_done  <= drain_hs_c;
            err_overlap <= frame_start && (state_q != ST_IDLE);
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= border_c ? PAD_VALUE : in_data;
                out_sof   <= is_sol && (row == '0);
                out_eol   <= is_eol;
                out_eof   <= is_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
